// File: rtl/dsp_pkg.sv
// Shared defaults and helpers for the ADC-to-FFT datapath.
// Includes the bit-reversal used to place samples in DIT input order.
package dsp_pkg;

    localparam int ADC_DATLEN    = 12;
    localparam int FFT_VLEN      = 16;
    localparam int FFT_VLEN_LOG2 = 4;

    localparam int BITREV_MAX_W  = 16;
    localparam int BITREV_IDX_W  = 4;

    typedef enum logic {
        RD_IDLE,
        RD_STREAM
    } rd_state_t;

    // Reverses the low log2_len bits of val; the upper bits come back as zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] val,
        input int                      log2_len
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < log2_len) begin
                r[BITREV_IDX_W'(i)] = val[BITREV_IDX_W'(log2_len - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank memory with one write port and one asynchronous read port.
// The bank is chosen per port, so capture and drain can use different banks at once.
module pingpong_ram #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:1][0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_bank][wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/dit_frame_buffer.sv
// Double-buffered framer: captures FFT_LEN pre-scaled ADC samples in bit-reversed order
// and streams whole frames to the FFT; frames that find no free bank are dropped whole.
module dit_frame_buffer
    import dsp_pkg::*;
#(
    parameter int DATA_W     = ADC_DATLEN,
    parameter int FFT_LEN    = FFT_VLEN,
    parameter int LOG2_LEN   = FFT_VLEN_LOG2,
    parameter int IN_SHIFT   = 1,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_W-1:0]   out_data,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] frames_dropped
);

    localparam logic [LOG2_LEN-1:0] LAST_IDX = LOG2_LEN'(FFT_LEN - 1);

    logic                    wb;
    logic                    rb;
    logic [1:0]              full;
    logic [1:0]              full_next;
    logic [LOG2_LEN-1:0]     w_idx;
    logic [LOG2_LEN-1:0]     r_idx;
    logic                    in_drop;
    logic                    drop_now;
    logic                    wr_en;
    logic                    wr_last;
    logic [DATA_W-1:0]       wr_data;
    logic [BITREV_MAX_W-1:0] rev_addr;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_last;
    logic                    rd_fire;
    logic                    rd_release;
    rd_state_t               rd_state;
    rd_state_t               rd_state_next;

    // The keep/drop decision is taken once at frame start and held for the whole frame.
    assign drop_now = (w_idx == '0) ? full[wb] : in_drop;
    assign wr_en    = in_valid & ~drop_now;
    assign wr_last  = wr_en & (w_idx == LAST_IDX);
    assign wr_data  = in_data >> IN_SHIFT;
    assign rev_addr = bitrev(BITREV_MAX_W'(w_idx), LOG2_LEN);

    pingpong_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (LOG2_LEN)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_bank (wb),
        .wr_addr (rev_addr[LOG2_LEN-1:0]),
        .wr_data (wr_data),
        .rd_bank (rb),
        .rd_addr (r_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            w_idx          <= '0;
            in_drop        <= 1'b0;
            wb             <= 1'b0;
            overflow       <= 1'b0;
            frames_dropped <= '0;
        end else if (in_valid) begin
            in_drop <= drop_now;
            if (w_idx == LAST_IDX) begin
                w_idx <= '0;
                if (drop_now) begin
                    overflow <= 1'b1;
                    if (frames_dropped != '1) begin
                        frames_dropped <= frames_dropped + DROP_CNT_W'(1);
                    end
                end else begin
                    wb <= ~wb;
                end
            end else begin
                w_idx <= w_idx + LOG2_LEN'(1);
            end
        end
    end

    // Release and completion always target different banks, so both may land in one cycle.
    always_comb begin
        full_next = full;
        if (rd_release) begin
            full_next[rb] = 1'b0;
        end
        if (wr_last) begin
            full_next[wb] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 2'b00;
        end else begin
            full <= full_next;
        end
    end

    assign rd_last    = (r_idx == LAST_IDX);
    assign rd_fire    = out_valid & out_ready;
    assign rd_release = rd_fire & rd_last;

    always_comb begin
        rd_state_next = rd_state;
        out_valid     = 1'b0;
        out_sof       = 1'b0;
        out_eof       = 1'b0;
        out_data      = '0;
        case (rd_state)
            RD_IDLE: begin
                if (full[rb]) begin
                    rd_state_next = RD_STREAM;
                end
            end
            RD_STREAM: begin
                out_valid = 1'b1;
                out_data  = {rd_data, {DATA_W{1'b0}}};
                out_sof   = (r_idx == '0);
                out_eof   = rd_last;
                if (out_ready && rd_last) begin
                    rd_state_next = RD_IDLE;
                end
            end
            default: rd_state_next = RD_IDLE;
        endcase
    end

    // r_idx wraps to zero on the last beat, so every frame starts from index 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            r_idx    <= '0;
            rb       <= 1'b0;
        end else begin
            rd_state <= rd_state_next;
            if (rd_fire) begin
                r_idx <= rd_last ? '0 : r_idx + LOG2_LEN'(1);
            end
            if (rd_release) begin
                rb <= ~rb;
            end
        end
    end

endmodule

// File: doc/dit_frame_buffer.md
# dit_frame_buffer

- Parametrised, double-buffered sample framer between the serial ADC reader and the radix-2 decimation-in-time FFT.
- Collects `FFT_LEN` consecutive ADC samples per frame, pre-scales each one, and stores it at its bit-reversed address.
- Streams each complete frame to the FFT as complex words over a valid/ready handshake, with start/end-of-frame markers.
- Ping-pong banks let capture continue while a frame drains; whole frames that cannot be buffered are dropped and counted, never truncated.

## Interface
Parameters:
- `DATA_W`, 12: ADC sample width.
- `FFT_LEN`, 16: samples per frame; power of two, ≥ 4.
- `LOG2_LEN`, 4: log2(`FFT_LEN`).
- `IN_SHIFT`, 1: logical right shift applied to each sample before storage.
- `DROP_CNT_W`, 8: width of the dropped-frame counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  one-cycle strobe per new ADC sample.
- `in_data`  in  `DATA_W`  unsigned ADC sample.
- `out_valid`  out  1  `out_data` holds a valid beat.
- `out_ready`  in  1  FFT accepts the beat.
- `out_data`  out  2*`DATA_W`  complex beat: `[2*DATA_W-1:DATA_W]` real, `[DATA_W-1:0]` imaginary (always 0).
- `out_sof`  out  1  first beat of a frame.
- `out_eof`  out  1  last beat of a frame.
- `overflow`  out  1  sticky; set on the first dropped frame.
- `frames_dropped`  out  `DROP_CNT_W`  saturating count of dropped frames.

## Operation
Storage and bank state:
- Two banks, each `FFT_LEN` x `DATA_W`.
- Write pointer `wb` and read pointer `rb`, each 1 bit.
- Per-bank `full[1:0]` flags.
- Write index `w_idx` and read index `r_idx`, each `LOG2_LEN` bits.

Write side, evaluated per `in_valid`:
- When `w_idx`==0, check `full[wb]`.
  - Clear: mode CAPTURE.
  - Set: mode DROP, for exactly `FFT_LEN` samples.
- CAPTURE: write `in_data >> IN_SHIFT` (zero-fill) to `bank[wb][bitrev(w_idx)]`, then increment `w_idx`.
  - On the write with `w_idx`==`FFT_LEN`-1: set `full[wb]`, toggle `wb`, set `w_idx`=0.
- DROP: discard the sample and increment the drop counter.
  - On the `FFT_LEN`th discarded sample: set `overflow`=1, increment `frames_dropped` (saturates at all-ones), return to the frame-start check.
  - A bank freed mid-drop does not end the drop early; frame alignment is preserved.
- `in_valid` is never back-pressured.

Read FSM:
- IDLE:
  - If `full[rb]`: go to STREAM with `r_idx`=0.
- STREAM:
  - `out_data` = {`bank[rb][r_idx]`, `DATA_W`'b0}.
  - `out_sof` = (`r_idx`==0); `out_eof` = (`r_idx`==`FFT_LEN`-1).
  - On `out_valid & out_ready`: increment `r_idx`.
  - On the `out_eof` beat: clear `full[rb]`, toggle `rb`, return to IDLE.

Ordering and arithmetic:
- Sequential reads of bit-reversed storage emit the DIT input order.
- No arithmetic beyond the shift and the counters.

## Timing
- Reset values:
  - Outputs: `out_valid`=0, `out_sof`=0, `out_eof`=0, `out_data`=0, `overflow`=0, `frames_dropped`=0.
  - Internal: `full`=00, `wb`=`rb`=0, `w_idx`=`r_idx`=0, read FSM IDLE, write side at frame start.
- Latency: `full` is set the cycle after the last sample's `in_valid`; `out_valid` rises one cycle after that (2 cycles total).
- Handshake:
  - `out_data`, `out_sof` and `out_eof` stay stable while `out_valid & !out_ready`.
  - `out_valid` never drops mid-frame.
- Inter-frame gap: exactly one idle cycle between an accepted `out_eof` and the next `out_sof`, even if the other bank is already full.
- Simultaneous events:
  - A write completing into one bank and the read releasing the other in the same cycle both take effect.
  - A sample arriving in the cycle a bank is released still sees that bank as full (registered `full`), and the frame is dropped.
- Reset mid-operation: the partial frame and both banks are discarded; `out_valid`=0 from the next cycle.

## Structure
- Shared package (`dsp_pkg`) holds `ADC_DATLEN`, `FFT_VLEN` and `FFT_VLEN_LOG2` defaults, plus a `bitrev` function parametrised on `LOG2_LEN`.
- One natural sub-module: `pingpong_ram`, a two-bank single-write/single-read memory with bank-select inputs.
- The FSM and counters stay in the top level.

## Test plan
- Reset, then 16 strobes with `in_data`=2k (k=0..15), `out_ready`=1:
  - Real part sequence is 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Imaginary part is always 0.
  - `out_sof` on beat 0, `out_eof` on beat 15.
  - First `out_valid` 2 cycles after the last strobe.
- `out_ready`=0, then 48 strobes:
  - The third frame is dropped: `overflow`=1, `frames_dropped`=1.
  - After releasing ready, exactly frames 1 and 2 emerge, separated by a 1-cycle gap.
  - Frame 4 is then captured normally.
- `out_ready` toggling every cycle:
  - Each beat is held stable while not accepted.
  - Order is unchanged and no beat is duplicated or lost.
- `DROP_CNT_W`=2, ready held low, 7 frames sent: `frames_dropped` saturates at 3.
- Assert `reset` after 9 samples of a frame, then send 16 fresh samples: only the fresh frame is emitted, and all outputs read 0 the cycle after reset.
- Write completion and `out_eof` acceptance forced into the same cycle: both banks' flags update correctly, and the next frame streams after the 1-cycle gap.
